// File: rtl/apollo_chip_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : apollo_chip_sequencer
//  Description : Timed, handshaked command engine for the Apollo in-memory
//                accelerator chip pins (CBL/CBLEN/CSL/CWL, instruction,
//                column/row address). It runs a SETUP/PULSE/WAIT/HOLD phase
//                sequence per command, synchronises the asynchronous DATA_out
//                bits, and returns one response per command.
//  Options     : define APOLLO_SEQ_PERF_EN to add a saturating completed-
//                command counter (perf_clr_i / perf_cmd_count_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module apollo_chip_sequencer #(
    parameter int NArray     = 4,
    parameter int ColW       = 5,
    parameter int RowW       = 5,
    parameter int CntW       = 8,
    parameter int SyncStages = 2
) (
    input  logic              clk_sys_in,
    input  logic              rst_sys_in,
    // Command channel
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_instr_i,
    input  logic [ColW-1:0]   cmd_col_i,
    input  logic [RowW-1:0]   cmd_row_i,
    input  logic              cmd_prog_val_i,
    // Phase timing
    input  logic [CntW-1:0]   cfg_setup_i,
    input  logic [CntW-1:0]   cfg_pulse_i,
    input  logic [CntW-1:0]   cfg_hold_i,
    // Response channel
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [NArray-1:0] rsp_data_o,
    output logic              busy_o,
    // Chip pins
    output logic [1:0]        chip_instr_o,
    output logic [ColW-1:0]   chip_col_o,
    output logic [RowW-1:0]   chip_row_o,
    output logic              chip_cbl_o,
    output logic              chip_cblen_o,
    output logic              chip_csl_o,
    output logic              chip_cwl_o,
    input  logic [NArray-1:0] chip_data_i
`ifdef APOLLO_SEQ_PERF_EN
    ,
    input  logic              perf_clr_i,
    output logic [15:0]       perf_cmd_count_o
`endif
);

    // Instruction encodings on the chip instruction bus
    localparam logic [1:0] c_instr_prog  = 2'b11;
    localparam logic [1:0] c_instr_rdmem = 2'b10;
    localparam logic [1:0] c_instr_rdreg = 2'b01;

    localparam logic [CntW-1:0] c_one  = CntW'(1);
    localparam logic [CntW-1:0] c_wait = CntW'(SyncStages);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t                       state_q;
    logic [CntW-1:0]              cnt_q;
    logic [CntW-1:0]              pulse_len_q;
    logic [CntW-1:0]              hold_len_q;
    logic                         prog_val_q;
    logic [1:0]                   instr_q;
    logic [ColW-1:0]              col_q;
    logic [RowW-1:0]              row_q;
    logic                         cbl_q;
    logic                         cblen_q;
    logic                         csl_q;
    logic                         cwl_q;
    logic                         rsp_valid_q;
    logic [NArray-1:0]            rsp_data_q;
    logic                         busy_q;
    logic                         cmd_ready_q;
    logic [SyncStages-1:0][NArray-1:0] sync_q;

    logic [NArray-1:0]            w_sync_data;
    logic [3:0]                   w_strb;       // {cbl, cblen, csl, cwl}
    logic                         w_is_prog;

    // A zero phase length is stretched to one cycle so every phase is visible
    function automatic logic [CntW-1:0] clamp_len(input logic [CntW-1:0] v);
        return (v == '0) ? c_one : v;
    endfunction

    // Metastability filter for the asynchronous DATA_out bits
    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], chip_data_i};
        end
    end

    assign w_sync_data = sync_q[SyncStages-1];

    // Strobe pattern for the latched instruction, applied during PULSE/WAIT
    always_comb begin
        w_strb = 4'b0000;
        case (instr_q)
            c_instr_prog:  w_strb = {prog_val_q, 1'b1, 1'b1, 1'b1};
            c_instr_rdmem: w_strb = 4'b0011;
            c_instr_rdreg: w_strb = 4'b0010;
            default:       w_strb = 4'b0101;   // inference: CWL + CBLEN
        endcase
    end

    assign w_is_prog = (instr_q == c_instr_prog);

    // Phase sequencer: state, counters, latched command and all pin outputs.
    // SETUP covers the launch cycle after accept plus S programmed cycles, so
    // the first response cycle lands 1+S+P+W+H cycles after the accept edge.
    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pulse_len_q <= '0;
            hold_len_q  <= '0;
            prog_val_q  <= 1'b0;
            instr_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cbl_q       <= 1'b0;
            cblen_q     <= 1'b0;
            csl_q       <= 1'b0;
            cwl_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        instr_q     <= cmd_instr_i;
                        col_q       <= cmd_col_i;
                        row_q       <= cmd_row_i;
                        prog_val_q  <= cmd_prog_val_i;
                        cnt_q       <= clamp_len(cfg_setup_i);
                        pulse_len_q <= clamp_len(cfg_pulse_i);
                        hold_len_q  <= clamp_len(cfg_hold_i);
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        {cbl_q, cblen_q, csl_q, cwl_q} <= w_strb;
                        cnt_q   <= pulse_len_q;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - c_one;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == c_one) begin
                        if (w_is_prog) begin
                            // Program has nothing to read back
                            {cbl_q, cblen_q, csl_q, cwl_q} <= 4'b0000;
                            rsp_data_q <= '0;
                            cnt_q      <= hold_len_q;
                            state_q    <= ST_HOLD;
                        end else begin
                            cnt_q   <= c_wait;
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q - c_one;
                    end
                end
                ST_WAIT: begin
                    // Strobes stay up while chip data settles through the synchroniser
                    if (cnt_q == c_one) begin
                        {cbl_q, cblen_q, csl_q, cwl_q} <= 4'b0000;
                        rsp_data_q <= w_sync_data;
                        cnt_q      <= hold_len_q;
                        state_q    <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - c_one;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == c_one) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - c_one;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    {cbl_q, cblen_q, csl_q, cwl_q} <= 4'b0000;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign busy_o       = busy_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign chip_instr_o = instr_q;
    assign chip_col_o   = col_q;
    assign chip_row_o   = row_q;
    assign chip_cbl_o   = cbl_q;
    assign chip_cblen_o = cblen_q;
    assign chip_csl_o   = csl_q;
    assign chip_cwl_o   = cwl_q;

`ifdef APOLLO_SEQ_PERF_EN
    logic [15:0] perf_cnt_q;
    logic        w_rsp_hs;

    assign w_rsp_hs = (state_q == ST_RESP) && rsp_ready_i;

    // Saturating count of completed responses; clear wins over a handshake
    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            perf_cnt_q <= '0;
        end else if (perf_clr_i) begin
            perf_cnt_q <= '0;
        end else if (w_rsp_hs && (perf_cnt_q != 16'hFFFF)) begin
            perf_cnt_q <= perf_cnt_q + 16'd1;
        end
    end

    assign perf_cmd_count_o = perf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apollo_chip_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apollo_chip_sequencer
//  Description : Self-checking bench for apollo_chip_sequencer. Expected pin
//                activity is derived from a per-command timeline model
//                (phase boundaries computed from S/P/W/H arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apollo_chip_sequencer;

    localparam int NA   = 4;
    localparam int CW   = 5;
    localparam int RW   = 5;
    localparam int KW   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_instr;
    logic [CW-1:0] cmd_col;
    logic [RW-1:0] cmd_row;
    logic          cmd_pv;
    logic [KW-1:0] cfg_s, cfg_p, cfg_h;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [NA-1:0] rsp_data;
    logic          busy;
    logic [1:0]    chip_instr;
    logic [CW-1:0] chip_col;
    logic [RW-1:0] chip_row;
    logic          cbl, cblen, csl, cwl;
    logic [NA-1:0] chip_data;
`ifdef APOLLO_SEQ_PERF_EN
    logic          perf_clr;
    logic [15:0]   perf_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int hs_model = 0;

    always #5 clk = ~clk;

    apollo_chip_sequencer #(
        .NArray(NA), .ColW(CW), .RowW(RW), .CntW(KW), .SyncStages(SYNC)
    ) dut (
        .clk_sys_in     (clk),
        .rst_sys_in     (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_instr_i    (cmd_instr),
        .cmd_col_i      (cmd_col),
        .cmd_row_i      (cmd_row),
        .cmd_prog_val_i (cmd_pv),
        .cfg_setup_i    (cfg_s),
        .cfg_pulse_i    (cfg_p),
        .cfg_hold_i     (cfg_h),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .busy_o         (busy),
        .chip_instr_o   (chip_instr),
        .chip_col_o     (chip_col),
        .chip_row_o     (chip_row),
        .chip_cbl_o     (cbl),
        .chip_cblen_o   (cblen),
        .chip_csl_o     (csl),
        .chip_cwl_o     (cwl),
        .chip_data_i    (chip_data)
`ifdef APOLLO_SEQ_PERF_EN
        ,
        .perf_clr_i       (perf_clr),
        .perf_cmd_count_o (perf_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe pattern {cbl,cblen,csl,cwl} the chip expects for each instruction
    function automatic logic [3:0] strobe_of(input logic [1:0] ins, input logic pv);
        case (ins)
            2'b11:   return {pv, 3'b111};
            2'b10:   return 4'b0011;
            2'b01:   return 4'b0010;
            default: return 4'b0101;
        endcase
    endfunction

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // One full command: accept, walk the phase timeline, respond after d stall
    // cycles (or with ready already high when early is set). Entered and left
    // on a falling edge with the DUT idle.
    task automatic run_cmd(input logic [1:0] ins, input logic [CW-1:0] col,
                           input logic [RW-1:0] row, input logic pv,
                           input int s, input int p, input int h,
                           input logic [NA-1:0] data, input int d, input bit early);
        int S, P, W, H, L, dd;
        logic [3:0]    est;
        logic [NA-1:0] edata;
        S = max1(s); P = max1(p); H = max1(h);
        W = (ins == 2'b11) ? 0 : SYNC;
        L = 1 + S + P + W + H;
        edata = (ins == 2'b11) ? '0 : data;
        dd = early ? 0 : d;

        cmd_instr = ins; cmd_col = col; cmd_row = row; cmd_pv = pv;
        cfg_s = KW'(s); cfg_p = KW'(p); cfg_h = KW'(h);
        chip_data = data; rsp_ready = 1'b0; cmd_valid = 1'b1;
        chk("ready_idle", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        chk("accept", {busy, cmd_ready, chip_instr, chip_col, chip_row},
            {1'b1, 1'b0, ins, col, row});

        // Pending traffic while busy must have no effect
        cmd_instr = 2'($urandom); cmd_col = CW'($urandom); cmd_row = RW'($urandom);
        cmd_pv = 1'($urandom); cfg_s = KW'($urandom); cfg_p = KW'($urandom);
        cfg_h = KW'($urandom);
        if (early) rsp_ready = 1'b1;

        for (int t = 0; t < L; t++) begin
            if (t > 0) begin @(posedge clk); @(negedge clk); end
            est = (t >= 1 + S && t < 1 + S + P + W) ? strobe_of(ins, pv) : 4'b0000;
            chk("timeline", {cbl, cblen, csl, cwl, rsp_valid, cmd_ready, busy,
                             chip_instr, chip_col, chip_row},
                {est, 1'b0, 1'b0, 1'b1, ins, col, row});
        end
        for (int k = 0; k <= dd; k++) begin
            @(posedge clk); @(negedge clk);
            chk("response", {rsp_valid, rsp_data, cbl, cblen, csl, cwl, cmd_ready},
                {1'b1, edata, 4'b0000, 1'b0});
            if (k == dd) rsp_ready = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        hs_model++;
        rsp_ready = 1'b0;
        chk("post_hs", {rsp_valid, cmd_ready, busy, chip_instr, chip_col, chip_row},
            {1'b0, 1'b1, 1'b0, ins, col, row});
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_instr = '0; cmd_col = '0; cmd_row = '0;
        cmd_pv = 1'b0; cfg_s = '0; cfg_p = '0; cfg_h = '0; rsp_ready = 1'b0;
        chip_data = '0;
`ifdef APOLLO_SEQ_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_state", {chip_instr, chip_col, chip_row, cbl, cblen, csl, cwl,
                            cmd_ready, rsp_valid, busy, rsp_data},
            {2'b00, 5'd0, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0});
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset", {cmd_ready, rsp_valid, busy}, 3'b100);

        // read_mem: 9-cycle latency, CWL/CSL high for pulse+wait = 5 cycles
        run_cmd(2'b10, 5'h0A, 5'h13, 1'b0, 2, 3, 1, 4'b1010, 0, 1'b0);
        // program with zero setup/hold
        run_cmd(2'b11, 5'h1F, 5'h01, 1'b1, 0, 4, 0, 4'b1111, 2, 1'b0);
        // back-pressure, then the next command right after the handshake
        run_cmd(2'b01, 5'h05, 5'h0C, 1'b0, 1, 2, 1, 4'b0110, 10, 1'b0);
        run_cmd(2'b00, 5'h11, 5'h02, 1'b0, 1, 1, 1, 4'b1001, 0, 1'b0);
        // ready already high before RESP
        run_cmd(2'b10, 5'h03, 5'h04, 1'b0, 0, 0, 0, 4'b0101, 0, 1'b1);
        // largest pulse length does not wrap
        run_cmd(2'b00, 5'h07, 5'h08, 1'b0, 1, 255, 1, 4'b0011, 0, 1'b0);

        // Reset during PULSE of read_reg: strobe drops at once, no response
        cmd_instr = 2'b01; cmd_col = 5'h09; cmd_row = 5'h0E; cmd_pv = 1'b0;
        cfg_s = 8'd1; cfg_p = 8'd6; cfg_h = 8'd1; cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        chk("csl_in_pulse", {60'd0, cbl, cblen, csl, cwl}, 64'b0010);
        #1 rst = 1'b1;
        #1 chk("async_reset", {cbl, cblen, csl, cwl, cmd_ready, busy, rsp_valid},
               {4'b0000, 1'b1, 1'b0, 1'b0});
        hs_model = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_reset", {rsp_valid, cmd_ready, busy}, 3'b010);
        run_cmd(2'b01, 5'h09, 5'h0E, 1'b0, 1, 2, 1, 4'b1100, 1, 1'b0);

        // Randomised commands against the timeline model
        for (int i = 0; i < 20; i++) begin
            run_cmd(2'($urandom), CW'($urandom), RW'($urandom), 1'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), NA'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

`ifdef APOLLO_SEQ_PERF_EN
        chk("perf_count", {48'd0, perf_cnt}, 64'(hs_model > 65535 ? 65535 : hs_model));
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        chk("perf_clear", {48'd0, perf_cnt}, 64'd0);
        hs_model = 0;
        run_cmd(2'b10, 5'h01, 5'h01, 1'b0, 0, 0, 0, 4'b0001, 0, 1'b0);
        run_cmd(2'b11, 5'h02, 5'h02, 1'b0, 0, 0, 0, 4'b0001, 0, 1'b0);
        run_cmd(2'b01, 5'h03, 5'h03, 1'b0, 0, 0, 0, 4'b0001, 0, 1'b0);
        chk("perf_three", {48'd0, perf_cnt}, 64'(hs_model));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apollo_chip_sequencer.md
Name: apollo_chip_sequencer

Overview:
- Parametrised command sequencer for the Apollo in-memory accelerator chip pins: CBL, CBLEN, CSL, CWL, instruction, column/row address, and the DATA_out bus.
- Replaces static wiring of those pins with a timed, handshaked command engine.
- Accepts one command on a valid/ready interface and drives the chip through programmable setup, pulse and hold phases.
- Synchronises the asynchronous DATA_out bits and returns one response per command.
- Sits between the pinaipple_system bus peripheral and the top-level chip pads.

Parameters:
- NArray, 4, number of chip DATA_out bits and width of the response data.
- ColW, 5, width of the full column address (array_col + mem_col).
- RowW, 5, width of the full row address (array_row + mem_row).
- CntW, 8, width of the timing counters and cfg_* inputs.
- SyncStages, 2, flip-flop depth of the DATA_out synchroniser; legal values are 2 and above.

Ports:
- clk_sys_in  in  1  system clock, the only clock.
- rst_sys_in  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; high only in IDLE.
- cmd_instr_i  in  2  11 form/prog, 10 read_mem, 01 read_reg, 00 inference.
- cmd_col_i  in  ColW  column address.
- cmd_row_i  in  RowW  row address.
- cmd_prog_val_i  in  1  CBL level driven during program.
- cfg_setup_i  in  CntW  setup phase length in cycles.
- cfg_pulse_i  in  CntW  pulse phase length in cycles.
- cfg_hold_i  in  CntW  hold phase length in cycles.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  NArray  captured chip data.
- busy_o  out  1  high in any state other than IDLE.
- chip_instr_o  out  2  chip instruction bus.
- chip_col_o  out  ColW  chip column address.
- chip_row_o  out  RowW  chip row address.
- chip_cbl_o, chip_cblen_o, chip_csl_o, chip_cwl_o  out  1 each  chip strobes.
- chip_data_i  in  NArray  chip DATA_out; asynchronous to clk_sys_in.

Behaviour:
- States: IDLE, SETUP, PULSE, WAIT, HOLD, RESP.
- Reset (asynchronous):
  - State goes to IDLE.
  - All chip_* outputs, rsp_valid_o, rsp_data_o and busy_o go to 0.
  - cmd_ready_o is 1 while in reset.
  - Synchroniser flops clear to 0.
- Reset mid-operation: strobes drop immediately and the in-flight command is discarded with no response.
- IDLE:
  - Accept on cmd_valid_i & cmd_ready_o.
  - Latch instr, col, row, prog_val and all three cfg_* values.
  - Go to SETUP.
  - cfg_* changes after accept do not affect the command in flight.
- chip_instr_o, chip_col_o and chip_row_o:
  - Update from the latched values on the accept edge.
  - Hold through HOLD and until the next accept; they do not return to 0.
- Phase lengths: a value of 0 is treated as 1.
  - S = max(cfg_setup, 1), P = max(cfg_pulse, 1), H = max(cfg_hold, 1).
- SETUP: S cycles, all strobes 0.
- PULSE: P cycles; strobes are registered outputs, asserted for exactly P cycles per instruction:
  - 11 program: CWL=1, CSL=1, CBLEN=1, CBL=prog_val.
  - 10 read_mem: CWL=1, CSL=1, CBLEN=0, CBL=0.
  - 01 read_reg: CSL=1 only.
  - 00 inference: CWL=1, CBLEN=1, CSL=0, CBL=0.
- WAIT (reads and inference only):
  - W = SyncStages cycles; PULSE strobe values held.
  - On the last WAIT cycle, rsp_data_o captures the synchronised chip_data_i.
  - Program skips WAIT (W = 0) and sets rsp_data_o = 0.
- HOLD: H cycles, all strobes 0, address and instruction unchanged.
- RESP:
  - rsp_valid_o = 1 and rsp_data_o stable until rsp_ready_i.
  - On handshake: rsp_valid_o drops next cycle and state returns to IDLE.
  - The next command is acceptable one cycle after the response handshake.
  - rsp_ready_i held high before RESP does not shorten RESP below 1 cycle.
- Latency: first rsp_valid_o cycle is 1+S+P+W+H cycles after the accept edge.
- Counters:
  - Down-counters of CntW bits loaded at phase entry.
  - No wrap: the maximum cfg value (2^CntW-1) gives exactly that many cycles.
- Simultaneous events: cmd_valid_i outside IDLE is ignored, with no effect and no loss of the in-flight command.

Optional Feature:
- Macro: APOLLO_SEQ_PERF_EN.
- With the macro defined, two extra ports are added:
  - perf_clr_i (in, 1).
  - perf_cmd_count_o (out, 16): counts completed response handshakes, saturates at 0xFFFF, and is cleared synchronously by perf_clr_i.
  - perf_clr_i coincident with a handshake gives a count of 0.
  - perf_cmd_count_o resets to 0.
- Without the macro: the ports and counter are absent and all other behaviour is identical.

Test Plan:
- Reset check: after reset, all chip_* outputs = 0, cmd_ready_o = 1, rsp_valid_o = 0.
- read_mem latency: setup=2, pulse=3, hold=1, SyncStages=2, col=5'h0A, row=5'h13, chip_data_i=4'b1010 →
  - chip_instr_o=10 and addresses valid from the accept edge.
  - CWL and CSL high for 5 cycles (pulse + wait).
  - rsp_valid_o first asserts 9 cycles after accept, with rsp_data_o = 4'b1010.
- Program with a zero phase: program, prog_val=1, setup=0, pulse=4, hold=0 →
  - CBL, CBLEN, CWL and CSL high for exactly 4 cycles.
  - rsp_data_o = 0; rsp_valid_o at cycle 7.
- Back-pressure: rsp_ready_i held low 10 cycles with a second cmd_valid_i pending →
  - rsp_valid_o and rsp_data_o stable throughout; cmd_ready_o = 0.
  - Second command accepted exactly 1 cycle after the handshake.
- Reset during PULSE: rst_sys_in asserted during PULSE of read_reg → CSL drops asynchronously, no response issued, next command completes normally.
- APOLLO_SEQ_PERF_EN: 3 commands then perf_clr_i → perf_cmd_count_o reads 3, then 0. Forcing the counter to 0xFFFF plus one command leaves it at 0xFFFF.
